// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned digit_count(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned count_width(input int unsigned width, input int unsigned digit);
        int unsigned n;
        n = width / digit;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned digit);
        return (width >= 1) && (width <= 64) && (digit >= 1) && (digit <= width) &&
               ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Full-adder cell and the DIGIT-bit ripple chain used once per RUN cycle.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic             ci,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        fulladd u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per cycle.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);
    localparam int unsigned N  = digit_count(WIDTH, DIGIT);
    localparam int unsigned CW = count_width(WIDTH, DIGIT);

    if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
        $error("serial_adder: WIDTH must be 1..64 and a multiple of DIGIT (1..WIDTH)");
    end

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_shift;
    logic [WIDTH-1:0] sum_top;
    logic             carry;
    logic [DIGIT-1:0] digit_sum;
    logic             digit_co;
    logic             digit_cmsb;
    logic             accept;
    logic             last_digit;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .ci    (carry),
        .a     (x_sr[DIGIT-1:0]),
        .b     (y_sr[DIGIT-1:0]),
        .sum   (digit_sum),
        .co    (digit_co),
        .c_msb (digit_cmsb)
    );

    // Shift-and-OR form stays legal when DIGIT == WIDTH (no zero-width slice).
    assign sum_top = WIDTH'(digit_sum) << (WIDTH - DIGIT);
    assign s_shift = (s_sr >> DIGIT) | sum_top;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_digit = 1'b0;
        case (state)
            IDLE: begin
                accept = Start;
                if (Start) state_next = RUN;
            end
            RUN: begin
                last_digit = (cnt == CW'(N - 1));
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                accept     = Start;
                state_next = Start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt      <= '0;
            x_sr     <= '0;
            y_sr     <= '0;
            s_sr     <= '0;
            carry    <= 1'b0;
            S        <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            x_sr  <= X;
            y_sr  <= Sub ? ~Y : Y;
            s_sr  <= '0;
            carry <= Sub ? 1'b1 : Cin;
        end else if (state == RUN) begin
            cnt   <= cnt + 1'b1;
            x_sr  <= x_sr >> DIGIT;
            y_sr  <= y_sr >> DIGIT;
            s_sr  <= s_shift;
            carry <= digit_co;
            if (last_digit) begin
                S        <= s_shift;
                Cout     <= digit_co;
                Overflow <= digit_co ^ digit_cmsb;
            end
        end
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 16/4 configuration plus an 8/8 single-cycle instance.
module tb_serial_adder;

    typedef struct {
        logic        sub;
        logic        cin;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] x, y, s;
    logic        cout, ovf, busy, done;

    logic        b_start, b_sub, b_cin;
    logic [7:0]  b_x, b_y, b_s;
    logic        b_cout, b_ovf, b_busy, b_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Start    (start),
        .Sub      (sub),
        .Cin      (cin),
        .X        (x),
        .Y        (y),
        .S        (s),
        .Cout     (cout),
        .Overflow (ovf),
        .Busy     (busy),
        .Done     (done)
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut_b (
        .Clock    (clk),
        .Reset    (rst),
        .Start    (b_start),
        .Sub      (b_sub),
        .Cin      (b_cin),
        .X        (b_x),
        .Y        (b_y),
        .S        (b_s),
        .Cout     (b_cout),
        .Overflow (b_ovf),
        .Busy     (b_busy),
        .Done     (b_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic sb, input logic ci, input logic [15:0] xa, input logic [15:0] ya);
        @(negedge clk);
        start = 1'b1;
        sub   = sb;
        cin   = ci;
        x     = xa;
        y     = ya;
    endtask

    // Presents one operation, then checks latency, Busy span, results and single-cycle Done.
    task automatic run_a(input string name, input vec_t v);
        int lat;
        int bn;
        logic [15:0] held;
        lat  = 0;
        bn   = 0;
        held = 16'hxxxx;
        issue(v.sub, v.cin, v.x, v.y);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin
                lat  = k;
                held = s;
                chk({name, "_s"}, 64'(s), 64'(v.s));
                chk({name, "_cout"}, 64'(cout), 64'(v.cout));
                chk({name, "_ovf"}, 64'(ovf), 64'(v.ovf));
                break;
            end
            if (busy) bn++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd5);
        chk({name, "_busy_cycles"}, 64'(bn), 64'd4);
        @(negedge clk);
        chk({name, "_done_single"}, 64'(done), 64'd0);
        chk({name, "_s_hold"}, 64'(s), 64'(held));
    endtask

    task automatic run_b(input string name, input logic sb, input logic ci, input logic [7:0] xa,
                         input logic [7:0] ya, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        int bn;
        lat = 0;
        bn  = 0;
        @(negedge clk);
        b_start = 1'b1;
        b_sub   = sb;
        b_cin   = ci;
        b_x     = xa;
        b_y     = ya;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) b_start = 1'b0;
            if (b_done) begin
                lat = k;
                chk({name, "_s"}, 64'(b_s), 64'(es));
                chk({name, "_cout"}, 64'(b_cout), 64'(ec));
                chk({name, "_ovf"}, 64'(b_ovf), 64'(eo));
                break;
            end
            if (b_busy) bn++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd2);
        chk({name, "_busy_cycles"}, 64'(bn), 64'd1);
    endtask

    initial begin
        vec_t vecs[10];
        int   d1, d2, extra, saw_done;

        vecs[0] = '{sub: 1'b0, cin: 1'b0, x: 16'hFFFF, y: 16'h0001, s: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[1] = '{sub: 1'b0, cin: 1'b0, x: 16'h7FFF, y: 16'h0001, s: 16'h8000, cout: 1'b0, ovf: 1'b1};
        vecs[2] = '{sub: 1'b0, cin: 1'b1, x: 16'h1234, y: 16'h0000, s: 16'h1235, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{sub: 1'b1, cin: 1'b1, x: 16'h0005, y: 16'h0007, s: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{sub: 1'b1, cin: 1'b0, x: 16'h8000, y: 16'h0001, s: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{sub: 1'b0, cin: 1'b0, x: 16'h8000, y: 16'h8000, s: 16'h0000, cout: 1'b1, ovf: 1'b1};
        vecs[6] = '{sub: 1'b1, cin: 1'b0, x: 16'h1234, y: 16'h1234, s: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[7] = '{sub: 1'b0, cin: 1'b1, x: 16'hABCD, y: 16'h1111, s: 16'hBCDF, cout: 1'b0, ovf: 1'b0};
        vecs[8] = '{sub: 1'b0, cin: 1'b0, x: 16'h00FF, y: 16'h0F01, s: 16'h1000, cout: 1'b0, ovf: 1'b0};
        vecs[9] = '{sub: 1'b1, cin: 1'b0, x: 16'h0003, y: 16'h0009, s: 16'hFFFA, cout: 1'b0, ovf: 1'b0};

        rst = 1'b1;
        start = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;
        b_start = 1'b0; b_sub = 1'b0; b_cin = 1'b0; b_x = '0; b_y = '0;
        repeat (2) @(negedge clk);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_b_s", 64'(b_s), 64'd0);
        chk("rst_b_done", 64'(b_done), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_a($sformatf("vec%0d", i), vecs[i]);
        end

        // Start during RUN is ignored; Start coincident with Done chains a second op.
        d1 = 0; d2 = 0; extra = 0;
        issue(1'b0, 1'b0, 16'h0001, 16'h0001);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1 || k == 3) start = 1'b0;
            if (done) begin
                if (d1 == 0) begin
                    d1 = k;
                    chk("b2b_first_s", 64'(s), 64'h0002);
                    chk("b2b_first_busy", 64'(busy), 64'd0);
                    start = 1'b1; sub = 1'b0; cin = 1'b0; x = 16'h0003; y = 16'h0004;
                end else if (d2 == 0) begin
                    d2 = k;
                    chk("b2b_second_s", 64'(s), 64'h0007);
                end else begin
                    extra++;
                end
            end
            if (k == 2) begin
                start = 1'b1; x = 16'hAAAA; y = 16'hAAAA;
            end
            if (d1 != 0 && k == d1 + 1) begin
                start = 1'b0;
                chk("b2b_no_idle_busy", 64'(busy), 64'd1);
            end
        end
        chk("b2b_first_cycle", 64'(d1), 64'd5);
        chk("b2b_second_cycle", 64'(d2), 64'd10);
        chk("b2b_extra_done", 64'(extra), 64'd0);

        // Reset mid-operation aborts it and clears held results.
        saw_done = 0;
        issue(1'b0, 1'b0, 16'h1111, 16'h2222);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) saw_done++;
            if (k == 4) begin
                chk("abort_s", 64'(s), 64'd0);
                chk("abort_cout", 64'(cout), 64'd0);
                chk("abort_ovf", 64'(ovf), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                rst = 1'b0;
            end
            if (k == 3) rst = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        run_a("post_reset",
              '{sub: 1'b0, cin: 1'b0, x: 16'h0F0F, y: 16'h0101, s: 16'h1010, cout: 1'b0, ovf: 1'b0});

        run_b("w8_carry", 1'b0, 1'b0, 8'hF0, 8'h10, 8'h00, 1'b1, 1'b0);
        run_b("w8_ovf", 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_b("w8_sub", 1'b1, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
